// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet framing controller: FSM states,
// error cause codes and the default frame start marker.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_HOLD    = 3'd4
    } pkt_state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // 8-bit additive checksum step; the carry is intentionally discarded
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: synchronous write, registered read. Storage is not reset;
// only the read register is, so rd_data comes out of reset as zero.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Framing controller behind the UART receiver: hunts SYNC, parses
// SYNC/LEN/payload/CSUM frames and holds verified packets for a consumer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// LEN     | waiting for length byte (1..MAX_LEN legal)
// PAYLOAD | storing payload bytes into the buffer, summing checksum
// CSUM    | waiting for checksum byte, compare against running sum
// HOLD    | verified packet presented; incoming bytes are overruns
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 208320,
    localparam int        LW           = $clog2(MAX_LEN + 1),
    localparam int        AW           = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_dv,
    input  logic [7:0]    rx_byte,
    output logic          pkt_valid,
    input  logic          pkt_ready,
    output logic [LW-1:0] pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int         TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

    pkt_state_t    state;
    logic [LW-1:0] len;
    logic [AW-1:0] idx;
    logic [7:0]    csum;
    logic [TW-1:0] timer;

    logic timed;
    logic expired;
    logic buf_we;
    logic last_payload;

    assign timed        = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    // a byte on the terminal-count cycle reloads the timer instead of firing
    assign expired      = timed && !rx_dv && (timer == '0);
    assign buf_we       = (state == ST_PAYLOAD) && rx_dv;
    assign last_payload = (LW'(idx) == (len - LW'(1)));
    assign busy         = (state != ST_IDLE);

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (idx),
        .wdata (rx_byte),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_TIMEOUT;
            len       <= '0;
            idx       <= '0;
            csum      <= 8'h00;
            timer     <= '0;
        end else begin
            err_pulse <= 1'b0;

            // inter-byte timer: reload on any byte and whenever not inside a frame
            if (timed && !rx_dv) begin
                timer <= timer - TW'(1);
            end else begin
                timer <= TIMER_LOAD;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (rx_dv) begin
                        if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= ST_IDLE;
                        end else begin
                            len   <= rx_byte[LW-1:0];
                            csum  <= rx_byte;
                            idx   <= '0;
                            state <= ST_PAYLOAD;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                    end
                end

                ST_PAYLOAD: begin
                    if (rx_dv) begin
                        csum <= csum_add(csum, rx_byte);
                        idx  <= idx + AW'(1);
                        if (last_payload) begin
                            state <= ST_CSUM;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                    end
                end

                ST_CSUM: begin
                    if (rx_dv) begin
                        if (rx_byte == csum) begin
                            pkt_valid <= 1'b1;
                            pkt_len   <= len;
                            state     <= ST_HOLD;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CSUM;
                            state     <= ST_IDLE;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    // buffer is frozen here: bytes (SYNC included) are dropped
                    if (rx_dv) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                    if (pkt_valid && pkt_ready) begin
                        pkt_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Framing controller behind the UART receiver.
- Consumes the receiver's one-cycle byte-valid strobe and data byte, and hunts for a sync byte.
- Parses a length-prefixed frame with an 8-bit additive checksum and captures the payload into an internal buffer.
- Presents a complete, verified packet to downstream logic through a valid/ready handshake plus a random-access read port; reports framing errors as one-cycle pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes (legal LEN range 1..MAX_LEN).
- TIMEOUT_CLKS, 208320, idle clocks allowed between bytes inside a frame (about 20 bit times at 10416 clocks per bit).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- rx_dv  in  1  byte-valid strobe from the UART receiver; one cycle per byte.
- rx_byte  in  8  received byte; qualified by rx_dv.
- pkt_valid  out  1  verified packet held in the buffer.
- pkt_ready  in  1  consumer releases the packet.
- pkt_len  out  $clog2(MAX_LEN+1)  payload length of the held packet.
- rd_addr  in  $clog2(MAX_LEN)  payload read index.
- rd_data  out  8  buffer[rd_addr], registered.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error cause: 0 timeout, 1 bad LEN, 2 bad checksum, 3 overrun; valid only with err_pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - State returns to IDLE.
  - pkt_valid, err_pulse, err_code, pkt_len, rd_data, busy and all counters are 0.
  - Buffer contents are not cleared.
  - Reset mid-frame discards the frame silently; no err_pulse.
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
  - CSUM = (LEN + sum of payload) mod 256.
- Every cycle with rx_dv=1 is one byte. Back-to-back rx_dv on consecutive cycles must be handled without loss.
- IDLE: on rx_dv with rx_byte==SYNC_BYTE, go to LEN; any other byte is ignored with no error.
- LEN: on rx_dv:
  - rx_byte==0 or rx_byte>MAX_LEN: err_pulse with code 1, go to IDLE.
  - Otherwise: latch the length, set csum=rx_byte, set idx=0, go to PAYLOAD.
- PAYLOAD: on rx_dv:
  - Write buffer[idx]=rx_byte, csum+=rx_byte (8-bit wrap), idx++.
  - After writing idx==len-1, go to CSUM.
  - A SYNC_BYTE value inside the payload is plain data.
- CSUM: on rx_dv:
  - rx_byte==csum: go to HOLD; pkt_valid=1 and pkt_len=len from the next cycle.
  - Otherwise: err_pulse with code 2, go to IDLE.
- HOLD:
  - pkt_valid and pkt_len are stable and the buffer is frozen.
  - pkt_valid & pkt_ready: pkt_valid drops the next cycle and state returns to IDLE.
  - pkt_ready while not pkt_valid has no effect.
  - Any rx_dv in HOLD: byte dropped, err_pulse with code 3, once per byte. A SYNC byte arriving in HOLD is also dropped, not hunted.
- Timeout (LEN, PAYLOAD, CSUM only):
  - Counter increments every clk and clears on rx_dv and on state entry.
  - When the counter reaches TIMEOUT_CLKS-1 with no rx_dv that cycle: err_pulse with code 0, go to IDLE.
  - If rx_dv coincides with expiry, the byte wins and no timeout fires.
- Read port:
  - rd_data <= buffer[rd_addr] every clk, giving 1-cycle latency, independent of state.
  - Data is meaningful only while pkt_valid.
  - rd_addr>=pkt_len returns stale but deterministic content.
- err_pulse lasts exactly one cycle per event; events never overlap because at most one byte arrives per cycle.

Decomposition:
- Package uart_pkt_pkg holds:
  - state encoding (IDLE, LEN, PAYLOAD, CSUM, HOLD);
  - err_code constants (ERR_TIMEOUT, ERR_LEN, ERR_CSUM, ERR_OVERRUN);
  - default SYNC_BYTE.
- Sub-module uart_pkt_buf:
  - MAX_LEN x 8 storage;
  - synchronous write port (we, waddr, wdata);
  - registered read port (raddr, rdata);
  - no reset on storage.

Test Plan:
1. Good frame: A5 03 11 22 33 69 -> pkt_valid=1, pkt_len=3; rd_addr 0,1,2 -> rd_data 11,22,33 one cycle later; pkt_ready=1 -> pkt_valid=0 next cycle, busy=0.
2. Bad checksum: A5 02 01 02 00 -> single err_pulse with code 2 on the cycle after the CSUM byte; pkt_valid stays 0; next good frame is accepted.
3. Bad length: A5 00 and A5 11 (17) -> err_pulse with code 1 each; following payload bytes are ignored in IDLE unless equal to A5.
4. Timeout: A5 02 01 then silence -> err_pulse with code 0 exactly TIMEOUT_CLKS cycles after the last rx_dv. Repeat with a byte landing on the expiry cycle -> no error, frame completes.
5. Overrun: hold a packet with pkt_ready=0 and send 3 bytes -> three err_pulse with code 3; buffer and pkt_len unchanged; then pkt_ready=1 -> IDLE.
6. Stress: garbage 00 FF 5A, then A5 01 A5 A6 with rx_dv on consecutive cycles, rst_n low mid-payload of another frame -> packet {A5} accepted; reset yields IDLE with no err_pulse.
